// File: rtl/axis_pixel_packer.sv
// Packs an 8-bit pixel stream into 32-bit AXI4-Stream beats, first pixel in bits [7:0].
// The final beat of each frame carries tlast/tkeep; frame_done pulses once it is accepted.
//   state     | meaning
//   FILL      | packing pixels into the accumulator, input open when the output slot can take a word
//   WAIT_LAST | tlast beat held in the output register, input blocked until it handshakes
module axis_pixel_packer #(
    parameter int FRAME_PIXELS = 262144,
    parameter int CNT_W        = $clog2(FRAME_PIXELS + 1)
) (
    input  logic        axi_clk,
    input  logic        axi_rst,
    input  logic        s_data_valid,
    input  logic [7:0]  s_data,
    output logic        s_data_ready,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        frame_done
);

    typedef enum logic {
        FILL      = 1'b0,
        WAIT_LAST = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

    state_t           state_q, state_d;
    logic [23:0]      acc_q, acc_d;
    logic [1:0]       lane_q, lane_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [31:0]      tdata_q, tdata_d;
    logic [3:0]       tkeep_q, tkeep_d;
    logic             tlast_q, tlast_d;
    logic             tvalid_q, tvalid_d;
    logic             frame_done_q, frame_done_d;

    logic s_acc;
    logic out_hs;
    logic last_pix;
    logic word_done;

    assign s_data_ready = (state_q == FILL) && (!tvalid_q || m_axis_tready);
    assign s_acc        = s_data_valid && s_data_ready;
    assign out_hs       = tvalid_q && m_axis_tready;
    assign last_pix     = (pix_cnt_q == LAST_IDX);
    assign word_done    = (lane_q == 2'd3) || last_pix;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        lane_d       = lane_q;
        pix_cnt_d    = pix_cnt_q;
        tdata_d      = tdata_q;
        tkeep_d      = tkeep_q;
        tlast_d      = tlast_q;
        tvalid_d     = tvalid_q;
        frame_done_d = 1'b0;

        if (out_hs) begin
            tvalid_d = 1'b0;
            if (state_q == WAIT_LAST && tlast_q) begin
                frame_done_d = 1'b1;
                state_d      = FILL;
            end
        end

        if (s_acc) begin
            if (word_done) begin
                // Lanes above the current one are still zero in acc, but mask explicitly anyway.
                case (lane_q)
                    2'd0:    begin tdata_d = {24'h0, s_data};               tkeep_d = 4'b0001; end
                    2'd1:    begin tdata_d = {16'h0, s_data, acc_q[7:0]};   tkeep_d = 4'b0011; end
                    2'd2:    begin tdata_d = {8'h0, s_data, acc_q[15:0]};   tkeep_d = 4'b0111; end
                    default: begin tdata_d = {s_data, acc_q};               tkeep_d = 4'b1111; end
                endcase
                tlast_d  = last_pix;
                tvalid_d = 1'b1;
                acc_d    = 24'h0;
                lane_d   = 2'd0;
                if (last_pix) begin
                    pix_cnt_d = '0;
                    state_d   = WAIT_LAST;
                end else begin
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                end
            end else begin
                case (lane_q)
                    2'd0:    acc_d[7:0]   = s_data;
                    2'd1:    acc_d[15:8]  = s_data;
                    default: acc_d[23:16] = s_data;
                endcase
                lane_d    = lane_q + 2'd1;
                pix_cnt_d = pix_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            state_q      <= FILL;
            acc_q        <= 24'h0;
            lane_q       <= 2'd0;
            pix_cnt_q    <= '0;
            tdata_q      <= 32'h0;
            tkeep_q      <= 4'h0;
            tlast_q      <= 1'b0;
            tvalid_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            lane_q       <= lane_d;
            pix_cnt_q    <= pix_cnt_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tlast_q      <= tlast_d;
            tvalid_q     <= tvalid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_axis_pixel_packer.sv
// Bench for axis_pixel_packer: instance 0 has 6-pixel frames, instance 1 has 8-pixel frames.
// A queue-based frame model is compared against both instances on every cycle.
module tb_axis_pixel_packer;

    localparam int FP0 = 6;
    localparam int FP1 = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid [2];
    logic [7:0]  s_data  [2];
    logic        s_ready [2];
    logic [31:0] tdata   [2];
    logic [3:0]  tkeep   [2];
    logic        tlast   [2];
    logic        tvalid  [2];
    logic        tready  [2];
    logic        fdone   [2];

    always #5 clk = ~clk;

    axis_pixel_packer #(.FRAME_PIXELS(FP0)) dut0 (
        .axi_clk(clk), .axi_rst(rst_n),
        .s_data_valid(s_valid[0]), .s_data(s_data[0]), .s_data_ready(s_ready[0]),
        .m_axis_tdata(tdata[0]), .m_axis_tkeep(tkeep[0]), .m_axis_tlast(tlast[0]),
        .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready[0]), .frame_done(fdone[0])
    );

    axis_pixel_packer #(.FRAME_PIXELS(FP1)) dut1 (
        .axi_clk(clk), .axi_rst(rst_n),
        .s_data_valid(s_valid[1]), .s_data(s_data[1]), .s_data_ready(s_ready[1]),
        .m_axis_tdata(tdata[1]), .m_axis_tkeep(tkeep[1]), .m_axis_tlast(tlast[1]),
        .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready[1]), .frame_done(fdone[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame model: pixels collected into words; beats are {last, keep, data}.
    logic [36:0] expq0 [$];
    logic [36:0] expq1 [$];
    logic [36:0] log0  [$];
    logic [36:0] log1  [$];
    logic [7:0]  m_pix  [2][4];
    int          m_n    [2];
    int          m_fcnt [2];
    bit          m_wait [2];
    bit          m_fd   [2];
    int          fd_cnt [2];
    bit          win1 = 0;
    int          low1 = 0;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_n[k] = 0; m_fcnt[k] = 0; m_wait[k] = 0; m_fd[k] = 0; fd_cnt[k] = 0;
        end
    end

    always @(negedge clk) begin
        logic [36:0] head;
        logic [31:0] word;
        bit          have, exp_ready, hs, last;
        int          fp;
        for (int k = 0; k < 2; k++) begin
            fp   = (k == 0) ? FP0 : FP1;
            have = (k == 0) ? (expq0.size() > 0) : (expq1.size() > 0);
            head = '0;
            if (have) head = (k == 0) ? expq0[0] : expq1[0];
            if (!rst_n) begin
                chk("rst_tvalid", 64'(tvalid[k]), 64'(0));
                chk("rst_tdata", 64'(tdata[k]), 64'(0));
                chk("rst_tkeep", 64'(tkeep[k]), 64'(0));
                chk("rst_tlast", 64'(tlast[k]), 64'(0));
                chk("rst_frame_done", 64'(fdone[k]), 64'(0));
                chk("rst_ready", 64'(s_ready[k]), 64'(1));
                expq0 = (k == 0) ? '{} : expq0;
                expq1 = (k == 1) ? '{} : expq1;
                m_n[k] = 0; m_fcnt[k] = 0; m_wait[k] = 0; m_fd[k] = 0;
            end else begin
                exp_ready = !m_wait[k] && (!have || tready[k]);
                chk("tvalid", 64'(tvalid[k]), 64'(have));
                chk("s_data_ready", 64'(s_ready[k]), 64'(exp_ready));
                chk("frame_done", 64'(fdone[k]), 64'(m_fd[k]));
                if (have) chk("beat", {27'h0, tlast[k], tkeep[k], tdata[k]}, 64'(head));
                if (tvalid[k] && tready[k]) begin
                    if (k == 0) log0.push_back({tlast[k], tkeep[k], tdata[k]});
                    else        log1.push_back({tlast[k], tkeep[k], tdata[k]});
                end
                if (fdone[k]) fd_cnt[k]++;
                if (k == 1 && win1 && !s_ready[k]) low1++;

                hs      = have && tready[k];
                m_fd[k] = hs && head[36];
                if (hs) begin
                    if (k == 0) void'(expq0.pop_front());
                    else        void'(expq1.pop_front());
                    if (head[36]) m_wait[k] = 0;
                end
                if (s_valid[k] && exp_ready) begin
                    m_pix[k][m_n[k]] = s_data[k];
                    m_n[k]++;
                    m_fcnt[k]++;
                    if (m_n[k] == 4 || m_fcnt[k] == fp) begin
                        word = '0;
                        for (int i = 0; i < m_n[k]; i++) word[8*i +: 8] = m_pix[k][i];
                        last = (m_fcnt[k] == fp);
                        if (k == 0) expq0.push_back({last, 4'((1 << m_n[k]) - 1), word});
                        else        expq1.push_back({last, 4'((1 << m_n[k]) - 1), word});
                        m_n[k] = 0;
                        if (last) begin
                            m_fcnt[k] = 0;
                            m_wait[k] = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int k, input logic [7:0] px);
        bit acc;
        int n;
        s_valid[k] = 1'b1;
        s_data[k]  = px;
        acc = 0;
        n   = 0;
        do begin
            @(negedge clk);
            acc = s_ready[k];
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=stalled expected=accepted px=%h", px);
        end
    endtask

    task automatic idle(input int k, input int n);
        s_valid[k] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 1'b0; s_data[k] = 8'h0; tready[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(0, 1);

        // continuous frame
        log0.delete(); fd_cnt[0] = 0;
        for (int i = 1; i <= 6; i++) send(0, 8'(i));
        idle(0, 6);
        chk("cont_nbeats", 64'(log0.size()), 64'(2));
        if (log0.size() == 2) begin
            chk("cont_beat1", 64'(log0[0]), {27'h0, 1'b0, 4'hF, 32'h04030201});
            chk("cont_beat2", 64'(log0[1]), {27'h0, 1'b1, 4'h3, 32'h00000605});
        end
        chk("cont_frame_done", 64'(fd_cnt[0]), 64'(1));

        // backpressure
        log0.delete(); fd_cnt[0] = 0;
        tready[0] = 1'b0;
        for (int i = 1; i <= 4; i++) send(0, 8'(i));
        s_valid[0] = 1'b1; s_data[0] = 8'h05;
        repeat (4) begin
            @(negedge clk);
            chk("bp_ready_low", 64'(s_ready[0]), 64'(0));
            chk("bp_tdata_hold", 64'(tdata[0]), 64'h04030201);
            chk("bp_tvalid_hold", 64'(tvalid[0]), 64'(1));
            @(posedge clk);
            #1;
        end
        tready[0] = 1'b1;
        #1 chk("bp_release_ready", 64'(s_ready[0]), 64'(1));
        send(0, 8'h05);
        send(0, 8'h06);
        idle(0, 6);
        chk("bp_nbeats", 64'(log0.size()), 64'(2));
        if (log0.size() == 2) begin
            chk("bp_beat1", 64'(log0[0]), {27'h0, 1'b0, 4'hF, 32'h04030201});
            chk("bp_beat2", 64'(log0[1]), {27'h0, 1'b1, 4'h3, 32'h00000605});
        end
        chk("bp_frame_done", 64'(fd_cnt[0]), 64'(1));

        // input gaps
        log0.delete();
        for (int i = 0; i < 6; i++) begin
            idle(0, $urandom_range(0, 3));
            send(0, 8'(8'h10 + i));
        end
        idle(0, 6);
        chk("gap_nbeats", 64'(log0.size()), 64'(2));
        if (log0.size() == 2) begin
            chk("gap_beat1", 64'(log0[0]), {27'h0, 1'b0, 4'hF, 32'h13121110});
            chk("gap_beat2", 64'(log0[1]), {27'h0, 1'b1, 4'h3, 32'h00001514});
        end

        // asynchronous reset with a stalled beat pending
        tready[0] = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 8'(8'h21 + i));
        idle(0, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tvalid", 64'(tvalid[0]), 64'(0));
        chk("arst_tdata", 64'(tdata[0]), 64'(0));
        chk("arst_tkeep", 64'(tkeep[0]), 64'(0));
        chk("arst_ready", 64'(s_ready[0]), 64'(1));
        @(posedge clk);
        #1 rst_n = 1'b1;
        tready[0] = 1'b1;
        #1 chk("arst_ready_after", 64'(s_ready[0]), 64'(1));

        // reset mid-frame
        idle(0, 1);
        for (int i = 0; i < 3; i++) send(0, 8'(8'h31 + i));
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        log0.delete();
        idle(0, 1);
        for (int i = 0; i < 6; i++) send(0, 8'(8'hA0 + i));
        idle(0, 6);
        chk("mid_nbeats", 64'(log0.size()), 64'(2));
        if (log0.size() == 2) begin
            chk("mid_beat1", 64'(log0[0]), {27'h0, 1'b0, 4'hF, 32'hA3A2A1A0});
            chk("mid_beat2", 64'(log0[1]), {27'h0, 1'b1, 4'h3, 32'h0000A5A4});
        end

        // back-to-back 8-pixel frames
        log1.delete(); fd_cnt[1] = 0; low1 = 0; win1 = 1;
        for (int i = 0; i < 16; i++) send(1, 8'(8'h40 + i));
        idle(1, 6);
        win1 = 0;
        chk("b2b_nbeats", 64'(log1.size()), 64'(4));
        if (log1.size() == 4) begin
            chk("b2b_beat1", 64'(log1[0]), {27'h0, 1'b0, 4'hF, 32'h43424140});
            chk("b2b_beat2", 64'(log1[1]), {27'h0, 1'b1, 4'hF, 32'h47464544});
            chk("b2b_beat3", 64'(log1[2]), {27'h0, 1'b0, 4'hF, 32'h4B4A4948});
            chk("b2b_beat4", 64'(log1[3]), {27'h0, 1'b1, 4'hF, 32'h4F4E4D4C});
        end
        chk("b2b_ready_low_cycles", 64'(low1), 64'(2));
        chk("b2b_frame_done", 64'(fd_cnt[1]), 64'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_pixel_packer.md
# axis_pixel_packer

Output-side stream packer for the image-processing pipeline. It sits directly downstream of the convolution output buffer and consumes its 8-bit pixel stream (`o_data`/`o_data_valid`/`i_data_ready` on the pipeline top). It packs four pixels into each 32-bit AXI4-Stream beat for the DMA write channel. It marks the final beat of every frame with `tlast` and `tkeep`, and pulses `frame_done` when that beat is accepted.

## Interface

Parameters
- `FRAME_PIXELS`, default 262144: number of 8-bit pixels per output frame. Must be >= 1.
- `CNT_W`, default `$clog2(FRAME_PIXELS+1)`: width of the pixel counter.

Ports
- `axi_clk`: input, 1 bit. Single clock; all logic is on its rising edge.
- `axi_rst`: input, 1 bit. Asynchronous, active-low reset.
- `s_data_valid`: input, 1 bit. Pixel valid from the output buffer.
- `s_data`: input, 8 bits. Pixel value.
- `s_data_ready`: output, 1 bit. The block accepts the pixel this cycle.
- `m_axis_tdata`: output, 32 bits. Packed pixels; the first pixel of the word is in bits [7:0].
- `m_axis_tkeep`: output, 4 bits. Valid byte lanes.
- `m_axis_tlast`: output, 1 bit. Final beat of the frame.
- `m_axis_tvalid`: output, 1 bit. Beat valid.
- `m_axis_tready`: input, 1 bit. Downstream (DMA) ready.
- `frame_done`: output, 1 bit. One-cycle pulse when the `tlast` beat handshakes.

## Operation

- Registers:
  - 24-bit accumulator `acc`.
  - 2-bit lane counter `lane` (0..3).
  - Pixel counter `pix_cnt` (0..FRAME_PIXELS-1).
  - One output register holding tdata, tkeep, tlast and tvalid.
  - FSM state.
- FSM states:
  - `FILL`: normal packing.
  - `WAIT_LAST`: the `tlast` beat is held and input is blocked.
- Input acceptance: `s_acc = s_data_valid && s_data_ready`.
- `s_data_ready` is combinational:
  - In `FILL`: `!m_axis_tvalid || m_axis_tready`.
  - In `WAIT_LAST`: 0.
- On `s_acc` where the pixel does not complete a word (lane < 3 and `pix_cnt` != FRAME_PIXELS-1):
  - Write `s_data` into `acc` lane `lane`.
  - Increment `lane` and `pix_cnt`.
- On `s_acc` where the pixel completes a word (lane == 3, or `pix_cnt` == FRAME_PIXELS-1):
  - Load the output register with `{s_data, acc}` masked to the filled lanes. Unused lanes are forced to 0x00.
  - `tkeep` = lanes 0..lane set (4'b1111 for a full word; 4'b0001/0011/0111 for a partial final word).
  - `tlast` = (`pix_cnt` == FRAME_PIXELS-1).
  - Set `tvalid` = 1. Clear `acc` and `lane`.
- End of frame:
  - If `tlast` is loaded: `pix_cnt` returns to 0 and the FSM enters `WAIT_LAST`.
  - Otherwise `pix_cnt` increments.
- Output beat handshake (`m_axis_tvalid && m_axis_tready`):
  - Clear `tvalid` unless a new word is loaded in the same cycle. Simultaneous drain and load is legal and gives back-to-back beats.
- In `WAIT_LAST`, on the `tlast` handshake:
  - Pulse `frame_done` for one cycle.
  - Return to `FILL`.
  - The next frame starts at lane 0, `pix_cnt` 0.
- Output registers do not change while `m_axis_tvalid && !m_axis_tready` (AXI stability rule).
- `s_data` is ignored while `s_data_ready` = 0. The upstream buffer holds it.

## Timing

- Reset values (asynchronous, `axi_rst` = 0):
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tkeep`=0, `m_axis_tlast`=0, `frame_done`=0.
  - FSM=`FILL`; `acc`, `lane`, `pix_cnt` = 0.
  - `s_data_ready` = 1 during and after reset, because it is derived from `FILL` and `tvalid`=0.
- Latency: a word-completing pixel accepted at edge N appears on `m_axis_tvalid` in the cycle after edge N.
- Throughput:
  - 1 pixel/cycle into the block; 1 beat per 4 cycles out when `m_axis_tready` stays 1.
  - At a frame boundary, one bubble cycle occurs at minimum: input is blocked from the load of the `tlast` beat until its handshake.
- Backpressure: when `m_axis_tready`=0 and a beat is pending, `s_data_ready`=0, even when the next pixel would not complete a word.
- Reset mid-frame: the partial word and the pending beat are discarded, and counters return to 0. The next pixel after reset is lane 0 of a new frame.
- `frame_done` asserts in the cycle after the `tlast` handshake edge and lasts exactly one cycle.

## Test plan

Run with `FRAME_PIXELS`=6 unless noted.

- **Reset:** assert `axi_rst`=0 mid-operation.
  - All outputs take their reset values immediately (asynchronous).
  - `s_data_ready`=1 after release.
- **Continuous frame:** send 0x01..0x06 back-to-back with `m_axis_tready`=1.
  - Beat 1: 0x04030201, tkeep=F, tlast=0.
  - Beat 2: 0x00000605, tkeep=3, tlast=1.
  - `frame_done` pulses once.
- **Backpressure:** hold `m_axis_tready`=0 after 4 pixels.
  - 0x04030201 stays stable and `s_data_ready`=0.
  - Release `m_axis_tready`: the beat handshakes and `s_data_ready` returns to 1 in the same cycle.
- **Input gaps:** toggle `s_data_valid` randomly over 0x10..0x15.
  - Beats are 0x13121110 (F) and 0x00001514 (3, last).
- **Back-to-back frames:** set `FRAME_PIXELS`=8 and send 16 pixels continuously.
  - Four beats, all tkeep=F.
  - tlast on beats 2 and 4.
  - `s_data_ready`=0 for exactly one cycle at each frame end.
  - `frame_done` pulses twice.
- **Reset mid-frame:** assert reset after 3 pixels, then send 0xA0..0xA5.
  - First beat is 0xA3A2A1A0 with no residue from before the reset.
